// File: rtl/pulse_burst_counter_if.sv
// Pulse input, burst report handshake and status bundle for pulse_burst_counter.
interface pulse_burst_counter_if #(
    parameter int unsigned CNT_W = 4
);
    logic             signal;
    logic             ready;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             valid;
    logic             busy;

    modport master (
        input  signal,
        input  ready,
        output count,
        output overflow,
        output valid,
        output busy
    );

    modport slave (
        output signal,
        output ready,
        input  count,
        input  overflow,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/pulse_burst_counter.sv
// Counts rising edges per burst of a pulse train and reports each burst on valid/ready.
// Define PULSE_BURST_SYNC_EN to add a two-flop synchronizer ahead of the edge detector.
module pulse_burst_counter #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    pulse_burst_counter_if.master bus
);
    localparam int unsigned      GAP_W    = $clog2(GAP);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_REPORT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic s2_q;
    logic s_prev_q;
    logic rise_c;

`ifdef PULSE_BURST_SYNC_EN
    logic s1_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            s1_q     <= bus.signal;
            s2_q     <= s1_q;
            s_prev_q <= s2_q;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_q     <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            s2_q     <= bus.signal;
            s_prev_q <= s2_q;
        end
    end
`endif

    assign rise_c = s2_q & ~s_prev_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // Burst tracking; an edge always wins over the quiet-gap close.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                gap_d = '0;
                ovf_d = 1'b0;
                if (rise_c) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (rise_c) begin
                    gap_d = '0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    count_d    = cnt_q;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
                    state_d    = ST_REPORT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_REPORT: begin
                if (valid_q && bus.ready) begin
                    valid_d    = 1'b0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    gap_d      = '0;
                    ovf_d      = 1'b0;
                    if (rise_c) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_pulse_burst_counter.sv
// Directed bench for pulse_burst_counter: event-timestamp burst model plus literal expectations.
module tb_pulse_burst_counter;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP   = 8;
    localparam int          MAXC  = (1 << CNT_W) - 1;
`ifdef PULSE_BURST_SYNC_EN
    localparam int          LAT   = 2;
`else
    localparam int          LAT   = 1;
`endif

    logic clock = 1'b0;
    logic reset_n;

    pulse_burst_counter_if #(.CNT_W(CNT_W)) bus ();

    pulse_burst_counter #(
        .CNT_W(CNT_W),
        .GAP  (GAP)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: edges from a sample history, bursts closed by timestamp distance.
    logic [2:0] hist;
    logic       m_e;
    int         cyc     = 0;
    int         m_cnt   = 0;
    int         m_last  = 0;
    bit         m_active = 1'b0;
    bit         m_rep   = 1'b0;
    int         rep_cnt = 0;
    bit         rep_ovf = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
        if (!reset_n) begin
            hist     = '0;
            m_active = 1'b0;
            m_rep    = 1'b0;
            m_cnt    = 0;
            m_last   = 0;
        end else begin
            m_e  = hist[LAT-1] & ~hist[LAT];
            hist = {hist[1:0], bus.signal};
            if (m_rep) begin
                if (bus.ready) begin
                    m_rep = 1'b0;
                    if (m_e) begin
                        m_active = 1'b1;
                        m_cnt    = 1;
                        m_last   = cyc;
                    end
                end
            end else if (m_active) begin
                if (m_e) begin
                    m_cnt  = m_cnt + 1;
                    m_last = cyc;
                end else if (cyc - m_last == int'(GAP)) begin
                    rep_cnt  = (m_cnt > MAXC) ? MAXC : m_cnt;
                    rep_ovf  = (m_cnt > MAXC);
                    m_rep    = 1'b1;
                    m_active = 1'b0;
                end
            end else if (m_e) begin
                m_active = 1'b1;
                m_cnt    = 1;
                m_last   = cyc;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        chk("valid",    int'(bus.valid),    int'(m_rep));
        chk("busy",     int'(bus.busy),     int'(m_active || m_rep));
        chk("count",    int'(bus.count),    m_rep ? rep_cnt : 0);
        chk("overflow", int'(bus.overflow), m_rep ? int'(rep_ovf) : 0);
    end

    // Every report has a rising valid; capture it once.
    int rq_cnt[$];
    int rq_ovf[$];
    bit last_v = 1'b0;

    initial forever begin
        @(negedge clock);
        if (bus.valid && !last_v) begin
            rq_cnt.push_back(int'(bus.count));
            rq_ovf.push_back(int'(bus.overflow));
        end
        last_v = bus.valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int low);
        bus.signal = 1'b1;
        tick(1);
        bus.signal = 1'b0;
        tick(low);
    endtask

    task automatic burst(input int n, input int low);
        repeat (n) pulse(low);
    endtask

    task automatic settle();
        tick(int'(GAP) + LAT + 4);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i = 0;
        while (!bus.valid && i < budget) begin
            tick(1);
            i++;
        end
        if (!bus.valid) begin
            n_total++;
            $display("FAIL %s: valid not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic expect_rep(input string name, input int c, input int o);
        if (rq_cnt.size() == 0) begin
            n_total++;
            $display("FAIL %s: no report seen, expected count %0d overflow %0d", name, c, o);
        end else begin
            chk({name, "_count"},    rq_cnt.pop_front(), c);
            chk({name, "_overflow"}, rq_ovf.pop_front(), o);
        end
    endtask

    task automatic expect_none(input string name);
        chk(name, rq_cnt.size(), 0);
        rq_cnt.delete();
        rq_ovf.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        reset_n    = 1'b0;
        bus.signal = 1'b0;
        bus.ready  = 1'b0;

        // Reset state
        tick(2);
        chk("rst_count",    int'(bus.count),    0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_valid",    int'(bus.valid),    0);
        chk("rst_busy",     int'(bus.busy),     0);
        reset_n = 1'b1;
        tick(2);

        // Basic burst of 3 with report latency
        bus.ready = 1'b1;
        burst(2, 2);
        bus.signal = 1'b1;
        lat = 0;
        for (int i = 1; i <= int'(GAP) + LAT + 4; i++) begin
            @(negedge clock);
            if (i == 1) bus.signal = 1'b0;
            if (bus.valid) begin
                lat = i;
                break;
            end
        end
        chk("t2_latency",  lat, LAT + int'(GAP) + 1);
        chk("t2_count",    int'(bus.count),    3);
        chk("t2_overflow", int'(bus.overflow), 0);
        tick(1);
        chk("t2_valid_drop", int'(bus.valid), 0);
        chk("t2_idle",       int'(bus.busy),  0);
        expect_rep("t2", 3, 0);
        settle();

        // Saturation, then a clean burst
        burst(17, 2);
        settle();
        expect_rep("t3_sat", 15, 1);
        burst(2, 2);
        settle();
        expect_rep("t3_next", 2, 0);

        // Backpressure with dropped pulses
        bus.ready = 1'b0;
        burst(3, 2);
        wait_valid("t4_wait", 30);
        for (int h = 0; h < 5; h++) begin
            bus.signal = (h == 0 || h == 2);
            tick(1);
            chk("t4_hold_valid", int'(bus.valid), 1);
            chk("t4_hold_count", int'(bus.count), 3);
        end
        bus.signal = 1'b0;
        bus.ready  = 1'b1;
        tick(1);
        chk("t4_valid_drop", int'(bus.valid), 0);
        chk("t4_idle",       int'(bus.busy),  0);
        settle();
        expect_rep("t4", 3, 0);
        expect_none("t4_no_extra");

        // Gap boundary: 7 quiet cycles merge, 8 split
        pulse(7);
        pulse(2);
        settle();
        expect_rep("t5_merge", 2, 0);
        expect_none("t5_merge_single");
        pulse(8);
        pulse(1);
        settle();
        expect_rep("t5_split_a", 1, 0);
        expect_rep("t5_split_b", 1, 0);
        expect_none("t5_split_only_two");

        // Reset mid-burst discards it
        burst(4, 2);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("t6a_busy", int'(bus.busy), 0);
        settle();
        expect_none("t6a_no_report");

        // Reset while a report is held
        bus.ready = 1'b0;
        burst(2, 2);
        wait_valid("t6b_wait", 30);
        reset_n = 1'b0;
        tick(1);
        chk("t6b_valid", int'(bus.valid), 0);
        chk("t6b_count", int'(bus.count), 0);
        expect_rep("t6b", 2, 0);
        reset_n   = 1'b1;
        bus.ready = 1'b1;
        settle();
        expect_none("t6b_no_report");

        // Level held through reset gives one edge; checks edge latency
        bus.signal = 1'b1;
        reset_n    = 1'b0;
        tick(2);
        reset_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= LAT + 4; i++) begin
            @(negedge clock);
            if (bus.busy) begin
                lat = i;
                break;
            end
        end
        chk("t6c_edge_latency", lat, LAT + 1);
        tick(5);
        bus.signal = 1'b0;
        settle();
        expect_rep("t6c", 1, 0);
        expect_none("t6c_single");

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
